// File: rtl/tx_pkg.sv
// tx_pkg: shared MAC datatype and result-encoder constants
// plus the S1 -> S2 bundle of the result encoder
package tx_pkg;

  typedef enum logic [1:0] {
    DT_FP16 = 2'd0,
    DT_FP8  = 2'd1,
    DT_INT9 = 2'd2
  } mac_datatype;

  localparam int FP16_BIAS = 15;
  localparam int FP8_BIAS  = 7;

  localparam logic [15:0] FP16_MAXFIN = 16'h7BFF;
  localparam logic [7:0]  FP8_MAXFIN  = 8'h7E;

  localparam int INT9_MAX = 255;
  localparam int INT9_MIN = -256;

  typedef struct packed {
    mac_datatype       dt;
    logic              zero;
    logic              sign;
    logic signed [9:0] bexp;
    logic [9:0]        keep;
    logic              guard;
    logic              sticky;
    logic [13:0]       mant;
  } s1_t;

endpackage

// File: rtl/mac_round_rne.sv
// mac_round_rne: round-to-nearest-even of a truncated mantissa
// carry reports a wrap of the mantissa into the exponent
module mac_round_rne #(
  parameter int W = 10
) (
  input  logic [W-1:0] mant,
  input  logic         guard,
  input  logic         sticky,
  output logic [W-1:0] rounded,
  output logic         carry
);

  logic inc;

  assign inc = guard & (sticky | mant[0]);

  assign {carry, rounded} =
    {1'b0, mant} + {{W{1'b0}}, inc};

endmodule

// File: rtl/mac_result_encoder.sv
// mac_result_encoder: packs normalized s/e/m beats
// into FP16, FP8 E4M3 or INT9 through two stages
module mac_result_encoder
  import tx_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  mac_datatype       i_datatype,
  input  logic              i_iszero,
  input  logic              i_sign,
  input  logic signed [7:0] i_exp,
  input  logic [13:0]       i_mant,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [15:0]       o_data,
  output logic              o_overflow,
  output logic              o_underflow
);

  logic signed [9:0] bias;
  logic signed [9:0] e_b;
  logic [9:0]        sh_raw;
  logic [3:0]        sh;
  logic              sub;
  logic [13:0]       mask;
  logic [12:0]       shd;
  logic              lost;

  s1_t  s1_d;
  s1_t  s1_q;
  logic s1_valid;
  logic s2_adv;

  logic [9:0]        r16;
  logic              c16;
  logic [2:0]        r8;
  logic              c8;
  logic signed [9:0] ef16;
  logic signed [9:0] ef8;
  logic [8:0]        iv;
  logic [15:0]       d_data;
  logic              d_ovf;
  logic              d_unf;

  assign s2_adv  = ~o_valid | i_ready;
  assign o_ready = ~s1_valid | s2_adv;

  // S1: bias, subnormal alignment, guard/sticky
  always_comb begin
    bias = (i_datatype == DT_FP8) ?
      10'(FP8_BIAS) : 10'(FP16_BIAS);
    e_b = $signed({{2{i_exp[7]}}, i_exp}) + bias;
    sub = (e_b <= 10'sd0);
    sh_raw = 10'd1 - $unsigned(e_b);
    sh = 4'd0;
    if (sub)
      sh = (sh_raw > 10'd14) ? 4'd14 : sh_raw[3:0];
    mask = (14'd1 << sh) - 14'd1;
    lost = |(i_mant & mask);
    shd = 13'(i_mant >> sh);

    s1_d = '0;
    s1_d.dt = i_datatype;
    s1_d.zero = i_iszero;
    s1_d.sign = i_sign;
    s1_d.mant = i_mant;
    s1_d.bexp = sub ? 10'sd0 : e_b;
    unique case (1'b1)
      (i_datatype == DT_FP8): begin
        s1_d.keep = {7'b0, shd[12:10]};
        s1_d.guard = shd[9];
        s1_d.sticky = (|shd[8:0]) | lost;
      end
      (i_datatype == DT_FP16): begin
        s1_d.keep = shd[12:3];
        s1_d.guard = shd[2];
        s1_d.sticky = (|shd[1:0]) | lost;
      end
      default: begin
        s1_d.keep = '0;
        s1_d.guard = 1'b0;
        s1_d.sticky = 1'b0;
      end
    endcase
  end

  mac_round_rne #(
    .W(10)
  ) u_rne16 (
    .mant    (s1_q.keep),
    .guard   (s1_q.guard),
    .sticky  (s1_q.sticky),
    .rounded (r16),
    .carry   (c16)
  );

  mac_round_rne #(
    .W(3)
  ) u_rne8 (
    .mant    (s1_q.keep[2:0]),
    .guard   (s1_q.guard),
    .sticky  (s1_q.sticky),
    .rounded (r8),
    .carry   (c8)
  );

  // S2: rounding carry, saturation, packing
  always_comb begin
    ef16 = s1_q.bexp + $signed({9'b0, c16});
    ef8 = s1_q.bexp + $signed({9'b0, c8});
    d_data = '0;
    d_ovf = 1'b0;
    d_unf = 1'b0;
    iv = '0;
    unique case (1'b1)
      (s1_q.dt == DT_INT9): begin
        if (s1_q.zero) begin
          iv = '0;
        end else if (s1_q.sign) begin
          d_ovf = s1_q.mant > 14'(-INT9_MIN);
          iv = d_ovf ? 9'(INT9_MIN) :
            9'd0 - s1_q.mant[8:0];
        end else begin
          d_ovf = s1_q.mant > 14'(INT9_MAX);
          iv = d_ovf ? 9'(INT9_MAX) :
            s1_q.mant[8:0];
        end
        d_data = {7'b0, iv};
      end
      (s1_q.dt == DT_FP8): begin
        if (s1_q.zero) begin
          d_data = {8'b0, s1_q.sign, 7'b0};
        end else if (ef8 > 10'sd15 ||
            (ef8 == 10'sd15 && r8 == 3'd7)) begin
          // S.1111.111 is reserved, so 0x7E is the ceiling
          d_data = {8'b0, s1_q.sign, FP8_MAXFIN[6:0]};
          d_ovf = 1'b1;
        end else begin
          d_data = {8'b0, s1_q.sign, ef8[3:0], r8};
          d_unf = (ef8 == 10'sd0) && (r8 == 3'd0);
        end
      end
      default: begin
        if (s1_q.zero) begin
          d_data = {s1_q.sign, 15'b0};
        end else if (ef16 >= 10'sd31) begin
          d_data = {s1_q.sign, FP16_MAXFIN[14:0]};
          d_ovf = 1'b1;
        end else begin
          d_data = {s1_q.sign, ef16[4:0], r16};
          d_unf = (ef16 == 10'sd0) && (r16 == 10'd0);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_q <= '0;
      o_valid <= 1'b0;
      o_data <= '0;
      o_overflow <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (o_ready) begin
        s1_valid <= i_valid;
        if (i_valid)
          s1_q <= s1_d;
      end
      if (s2_adv) begin
        o_valid <= s1_valid;
        if (s1_valid) begin
          o_data <= d_data;
          o_overflow <= d_ovf;
          o_underflow <= d_unf;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_result_encoder.sv
// tb_mac_result_encoder: scoreboard bench for the result packer
// random beats are checked against a value-level rounding model
module tb_mac_result_encoder;
  import tx_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_valid;
  logic              o_ready;
  mac_datatype       i_datatype;
  logic              i_iszero;
  logic              i_sign;
  logic signed [7:0] i_exp;
  logic [13:0]       i_mant;
  logic              o_valid;
  logic              i_ready;
  logic [15:0]       o_data;
  logic              o_overflow;
  logic              o_underflow;

  typedef struct {
    mac_datatype dt;
    logic        z;
    logic        s;
    logic [7:0]  e;
    logic [13:0] m;
  } beat_t;

  typedef struct {
    logic [15:0] d;
    logic        ov;
    logic        un;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   bp_mode = 0;

  always #5 clk = ~clk;

  mac_result_encoder dut (
    .clk         (clk),
    .reset       (reset),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_datatype  (i_datatype),
    .i_iszero    (i_iszero),
    .i_sign      (i_sign),
    .i_exp       (i_exp),
    .i_mant      (i_mant),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_overflow  (o_overflow),
    .o_underflow (o_underflow)
  );

  // round m / 2^k to nearest, ties to even
  function automatic longint rne(input longint m, input int k);
    longint q, r, h;
    if (k > 20) return 0;
    q = m >> k;
    r = m - (q << k);
    h = longint'(1) << (k - 1);
    if (r > h || (r == h && q[0])) q++;
    return q;
  endfunction

  // magnitude is built as a count of ulps on the target grid
  function automatic exp_t model(input beat_t b);
    exp_t   x;
    longint mag, n;
    int     e, ee, v;
    x.d = '0;
    x.ov = 1'b0;
    x.un = 1'b0;
    e = int'($signed(b.e));
    if (b.dt == DT_INT9) begin
      v = b.z ? 0 : (b.s ? -int'(b.m) : int'(b.m));
      if (v > INT9_MAX) begin v = INT9_MAX; x.ov = 1'b1; end
      if (v < INT9_MIN) begin v = INT9_MIN; x.ov = 1'b1; end
      x.d = 16'(v & 'h1FF);
    end else if (b.z) begin
      x.d = (b.dt == DT_FP8) ?
        {8'h0, b.s, 7'h0} : {b.s, 15'h0};
    end else if (b.dt == DT_FP8) begin
      if (e >= -6) begin
        n = rne(longint'(b.m), 10);
        ee = e;
        if (n == 16) begin n = 8; ee++; end
        mag = longint'(ee + 7) * 8 + n - 8;
      end else begin
        mag = rne(longint'(b.m), 4 - e);
      end
      if (mag > longint'(FP8_MAXFIN)) begin
        mag = longint'(FP8_MAXFIN);
        x.ov = 1'b1;
      end
      x.un = (mag == 0);
      x.d = {8'h0, b.s, 7'(mag)};
    end else begin
      if (e >= -14) begin
        n = rne(longint'(b.m), 3);
        ee = e;
        if (n == 2048) begin n = 1024; ee++; end
        mag = longint'(ee + 15) * 1024 + n - 1024;
      end else begin
        mag = rne(longint'(b.m), -e - 11);
      end
      if (mag > longint'(FP16_MAXFIN)) begin
        mag = longint'(FP16_MAXFIN);
        x.ov = 1'b1;
      end
      x.un = (mag == 0);
      x.d = {b.s, 15'(mag)};
    end
    return x;
  endfunction

  function automatic beat_t rnd_beat();
    beat_t b;
    int    k;
    k = int'($urandom_range(0, 9));
    b.dt = (k < 4) ? DT_FP16 : (k < 7) ? DT_FP8 : DT_INT9;
    b.z = ($urandom_range(0, 15) == 0);
    b.s = 1'($urandom_range(0, 1));
    if (b.dt == DT_INT9) begin
      b.e = 8'($urandom);
      b.m = ($urandom_range(0, 1) == 1) ?
        14'($urandom_range(0, 600)) : 14'($urandom);
    end else begin
      b.e = ($urandom_range(0, 3) == 0) ?
        8'($urandom) : 8'($urandom_range(0, 50) - 32);
      b.m = 14'h2000 | 14'($urandom & 'h1FFF);
      b.m = b.m & ~14'((1 << $urandom_range(0, 12)) - 1);
    end
    return b;
  endfunction

  task automatic chk(input string name, input logic [15:0] got,
                     input logic [15:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic drive(input beat_t b);
    i_valid = 1'b1;
    i_datatype = b.dt;
    i_iszero = b.z;
    i_sign = b.s;
    i_exp = b.e;
    i_mant = b.m;
  endtask

  task automatic send(input beat_t b, input exp_t x);
    int t;
    @(negedge clk);
    drive(b);
    t = 0;
    #4;
    while (!o_ready && t < 200) begin
      @(negedge clk);
      #4;
      t++;
    end
    if (o_ready) begin
      sb.push_back(x);
    end else begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: o_ready=%b want 1", o_ready);
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d pending want 0", sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic dir(input mac_datatype dt, input logic z,
                     input logic s, input int e,
                     input logic [13:0] m, input logic [15:0] d,
                     input logic ov, input logic un);
    beat_t b;
    exp_t  x;
    b.dt = dt; b.z = z; b.s = s; b.e = 8'(e); b.m = m;
    x.d = d; x.ov = ov; x.un = un;
    send(b, x);
  endtask

  // i_ready driver: 0 always, 1 random, 2 stalled, 3 manual
  initial begin
    i_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (bp_mode)
        0: i_ready = 1'b1;
        1: i_ready = ($urandom_range(0, 3) != 0);
        2: i_ready = 1'b0;
        default: ;
      endcase
    end
  end

  // monitor: every output transfer pops one expectation
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #4;
      if (!reset && o_valid && i_ready) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got %h want none",
                   o_data);
        end else begin
          x = sb.pop_front();
          if (o_data !== x.d || o_overflow !== x.ov ||
              o_underflow !== x.un) begin
            n_fail++;
            $display("FAIL beat: got %h ov=%b un=%b want %h ov=%b un=%b",
                     o_data, o_overflow, o_underflow,
                     x.d, x.ov, x.un);
          end
        end
      end
    end
  end

  initial begin
    beat_t bp_in[5];
    exp_t  bp_x[5];
    beat_t b;
    int    acc;

    reset = 1'b1;
    i_valid = 1'b0;
    i_datatype = DT_FP16;
    i_iszero = 1'b0;
    i_sign = 1'b0;
    i_exp = '0;
    i_mant = '0;
    repeat (3) @(negedge clk);
    #4;
    chk("rst_o_valid", 16'(o_valid), 16'd0);
    chk("rst_o_data", o_data, 16'h0000);
    chk("rst_o_overflow", 16'(o_overflow), 16'd0);
    chk("rst_o_underflow", 16'(o_underflow), 16'd0);
    chk("rst_o_ready", 16'(o_ready), 16'd1);
    @(negedge clk);
    reset = 1'b0;

    dir(DT_FP16, 0, 0, 0, 14'h2000, 16'h3C00, 0, 0);
    dir(DT_FP16, 0, 0, 0, 14'h2004, 16'h3C00, 0, 0);
    dir(DT_FP16, 0, 0, 0, 14'h200C, 16'h3C02, 0, 0);
    dir(DT_FP16, 0, 0, 0, 14'h3FFF, 16'h4000, 0, 0);
    dir(DT_FP16, 0, 0, 16, 14'h2000, 16'h7BFF, 1, 0);
    dir(DT_FP16, 0, 1, 16, 14'h2000, 16'hFBFF, 1, 0);
    dir(DT_FP16, 0, 0, -24, 14'h2000, 16'h0001, 0, 0);
    dir(DT_FP16, 0, 0, -25, 14'h2000, 16'h0000, 0, 1);
    dir(DT_FP16, 0, 0, -14, 14'h2000, 16'h0400, 0, 0);
    dir(DT_FP16, 0, 0, -15, 14'h3FFF, 16'h0400, 0, 0);
    dir(DT_FP16, 1, 1, 5, 14'h1234, 16'h8000, 0, 0);
    dir(DT_FP8, 0, 0, 0, 14'h2000, 16'h0038, 0, 0);
    dir(DT_FP8, 0, 0, 8, 14'h3FFF, 16'h007E, 1, 0);
    dir(DT_FP8, 0, 0, 8, 14'h3C00, 16'h007E, 1, 0);
    dir(DT_FP8, 0, 0, 8, 14'h3000, 16'h007C, 0, 0);
    dir(DT_FP8, 0, 0, -9, 14'h2000, 16'h0001, 0, 0);
    dir(DT_FP8, 0, 1, -10, 14'h2000, 16'h0080, 0, 1);
    dir(DT_FP8, 1, 1, 0, 14'h2000, 16'h0080, 0, 0);
    dir(DT_INT9, 0, 0, 0, 14'd5, 16'h0005, 0, 0);
    dir(DT_INT9, 0, 1, 0, 14'd5, 16'h01FB, 0, 0);
    dir(DT_INT9, 0, 1, 0, 14'd300, 16'h0100, 1, 0);
    dir(DT_INT9, 0, 0, 0, 14'd256, 16'h00FF, 1, 0);
    dir(DT_INT9, 0, 1, 0, 14'd256, 16'h0100, 0, 0);
    dir(DT_INT9, 0, 0, 9, 14'd255, 16'h00FF, 0, 0);
    idle();
    drain();

    bp_in[0] = '{DT_FP16, 1'b0, 1'b0, 8'd0, 14'h2000};
    bp_in[1] = '{DT_INT9, 1'b0, 1'b1, 8'd0, 14'd5};
    bp_in[2] = '{DT_FP8, 1'b0, 1'b0, 8'd8, 14'h3FFF};
    bp_in[3] = '{DT_FP16, 1'b0, 1'b0, 8'hE7, 14'h2000};
    bp_in[4] = '{DT_INT9, 1'b0, 1'b1, 8'd0, 14'd300};
    bp_x[0] = '{16'h3C00, 1'b0, 1'b0};
    bp_x[1] = '{16'h01FB, 1'b0, 1'b0};
    bp_x[2] = '{16'h007E, 1'b1, 1'b0};
    bp_x[3] = '{16'h0000, 1'b0, 1'b1};
    bp_x[4] = '{16'h0100, 1'b1, 1'b0};
    bp_mode = 3;
    acc = 0;
    for (int c = 0; c < 40 && acc < 5; c++) begin
      @(negedge clk);
      i_ready = (c >= 3);
      drive(bp_in[acc]);
      #4;
      if (c == 2) begin
        chk("bp_ready_low", 16'(o_ready), 16'd0);
        chk("bp_accepted", 16'(acc), 16'd2);
      end
      if (o_ready) begin
        sb.push_back(bp_x[acc]);
        acc++;
      end
    end
    chk("bp_all_accepted", 16'(acc), 16'd5);
    idle();
    bp_mode = 0;
    drain();

    bp_mode = 3;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      i_ready = 1'b0;
      drive(bp_in[c]);
    end
    @(negedge clk);
    i_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_o_valid", 16'(o_valid), 16'd0);
    chk("rst_mid_o_data", o_data, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    i_ready = 1'b1;
    bp_mode = 0;
    repeat (5) @(negedge clk);
    #4;
    chk("rst_no_stale", 16'(o_valid), 16'd0);
    dir(DT_FP8, 0, 0, 0, 14'h2000, 16'h0038, 0, 0);
    idle();
    drain();

    for (int i = 0; i < 600; i++) begin
      if (i == 300) bp_mode = 1;
      b = rnd_beat();
      send(b, model(b));
      if ($urandom_range(0, 7) == 0) idle();
    end
    idle();
    bp_mode = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
